// File: rtl/cache_miss_fsm_if.sv
// rtl/cache_miss_fsm_if.sv - AXI4-Lite write/read channels between the miss handler and memory
interface cache_miss_fsm_if;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
    );
endinterface

// File: rtl/cache_miss_fsm.sv
// rtl/cache_miss_fsm.sv - data cache miss handler: dirty victim write-back, word fetch, install pulse
module cache_miss_fsm #(
    parameter int LOAD_opcode  = 11,
    parameter int STORE_opcode = 12,
    parameter int opcode_width = 5,
    parameter int tag_width    = 18,
    parameter int index_width  = 10,
    parameter int offset_width = 4,
    parameter int total_width  = 32,
    parameter int N            = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    input  logic                    hit_i,
    input  logic [opcode_width-1:0] opcode_i,
    input  logic [total_width-1:0]  address_i,
    input  logic                    victim_valid_i,
    input  logic                    victim_dirty_i,
    input  logic [tag_width-1:0]    victim_tag_i,
    input  logic [total_width-1:0]  victim_data_i,
    output logic                    stall_o,
    output logic                    sel_o,
    output logic                    load_miss_o,
    output logic                    array_we_o,
    output logic [total_width-1:0]  axi_data_reg_o,
    output logic                    err_o,
    cache_miss_fsm_if.master        m
);

    if (N < 1) begin : g_bad_assoc
    end

    typedef enum logic [2:0] {IDLE, WB, WB_B, RD_A, RD_D, UPD} state_t;

    state_t                             state_q, state_d;
    logic [total_width-1:offset_width]  addr_q, addr_d;
    logic                               is_load_q, is_load_d;
    logic [tag_width-1:0]               vtag_q, vtag_d;
    logic [total_width-1:0]             vdata_q, vdata_d;
    logic                               aw_done_q, aw_done_d;
    logic                               w_done_q, w_done_d;
    logic [total_width-1:0]             data_q, data_d;
    logic                               err_q, err_d;
    logic                               stall_q, stall_d;
    logic                               upd_q, upd_d;
    logic                               load_miss_q, load_miss_d;
    logic                               awvalid_q, awvalid_d;
    logic                               wvalid_q, wvalid_d;
    logic                               bready_q, bready_d;
    logic                               arvalid_q, arvalid_d;
    logic                               rready_q, rready_d;

    logic is_mem_op;
    logic miss;
    logic wb_needed;

    assign is_mem_op = (opcode_i == opcode_width'(LOAD_opcode)) ||
                       (opcode_i == opcode_width'(STORE_opcode));
    assign miss      = req_valid_i && !hit_i && is_mem_op;
    assign wb_needed = victim_valid_i && victim_dirty_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        is_load_d = is_load_q;
        vtag_d    = vtag_q;
        vdata_d   = vdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        data_d    = data_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (miss) begin
                    addr_d    = address_i[total_width-1:offset_width];
                    is_load_d = (opcode_i == opcode_width'(LOAD_opcode));
                    vtag_d    = victim_tag_i;
                    vdata_d   = victim_data_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wb_needed ? WB : RD_A;
                end
            end
            WB: begin
                // AW and W complete independently; each valid drops once its own beat is taken
                if (m.m_awready) aw_done_d = 1'b1;
                if (m.m_wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = WB_B;
            end
            WB_B: begin
                if (m.m_bvalid) begin
                    if (m.m_bresp != 2'b00) err_d = 1'b1;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                if (m.m_arready) state_d = RD_D;
            end
            RD_D: begin
                if (m.m_rvalid) begin
                    data_d = m.m_rdata;
                    if (m.m_rresp != 2'b00) err_d = 1'b1;
                    state_d = UPD;
                end
            end
            UPD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it
        stall_d     = (state_d != IDLE);
        upd_d       = (state_d == UPD);
        load_miss_d = (state_d == UPD) && is_load_d;
        awvalid_d   = (state_d == WB) && !aw_done_d;
        wvalid_d    = (state_d == WB) && !w_done_d;
        bready_d    = (state_d == WB_B);
        arvalid_d   = (state_d == RD_A);
        rready_d    = (state_d == RD_D);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            is_load_q   <= 1'b0;
            vtag_q      <= '0;
            vdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            upd_q       <= 1'b0;
            load_miss_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            is_load_q   <= is_load_d;
            vtag_q      <= vtag_d;
            vdata_q     <= vdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            data_q      <= data_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            upd_q       <= upd_d;
            load_miss_q <= load_miss_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign stall_o        = stall_q;
    assign sel_o          = upd_q;
    assign array_we_o     = upd_q;
    assign load_miss_o    = load_miss_q;
    assign axi_data_reg_o = data_q;
    assign err_o          = err_q;

    assign m.m_awaddr  = {vtag_q, addr_q[offset_width+index_width-1:offset_width], {offset_width{1'b0}}};
    assign m.m_awvalid = awvalid_q;
    assign m.m_wdata   = vdata_q;
    assign m.m_wstrb   = wvalid_q ? 4'hF : 4'h0;
    assign m.m_wvalid  = wvalid_q;
    assign m.m_bready  = bready_q;
    assign m.m_araddr  = {addr_q, {offset_width{1'b0}}};
    assign m.m_arvalid = arvalid_q;
    assign m.m_rready  = rready_q;

endmodule

// File: tb/tb_cache_miss_fsm.sv
// tb/tb_cache_miss_fsm.sv - randomized self-checking bench for cache_miss_fsm
module tb_cache_miss_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        hit_i;
    logic [4:0]  opcode_i;
    logic [31:0] address_i;
    logic        victim_valid_i;
    logic        victim_dirty_i;
    logic [17:0] victim_tag_i;
    logic [31:0] victim_data_i;
    logic        stall_o;
    logic        sel_o;
    logic        load_miss_o;
    logic        array_we_o;
    logic [31:0] axi_data_reg_o;
    logic        err_o;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic err_model    = 1'b0;

    always #5 clk = ~clk;

    cache_miss_fsm_if bus ();

    cache_miss_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .hit_i          (hit_i),
        .opcode_i       (opcode_i),
        .address_i      (address_i),
        .victim_valid_i (victim_valid_i),
        .victim_dirty_i (victim_dirty_i),
        .victim_tag_i   (victim_tag_i),
        .victim_data_i  (victim_data_i),
        .stall_o        (stall_o),
        .sel_o          (sel_o),
        .load_miss_o    (load_miss_o),
        .array_we_o     (array_we_o),
        .axi_data_reg_o (axi_data_reg_o),
        .err_o          (err_o),
        .m              (bus.master)
    );

    task automatic clear_slave();
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'b00;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = 32'h0;
        bus.m_rresp   = 2'b00;
    endtask

    // Issues one miss and plays the memory side with the given per-channel ready/valid delays
    task automatic do_miss(input string name, input logic [31:0] addr, input logic ld,
                           input logic vv, input logic vd, input logic [17:0] vtag,
                           input logic [31:0] vdata, input logic [31:0] rdata,
                           input logic [1:0] bresp, input logic [1:0] rresp,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input int ar_dly, input int r_dly);
        logic        wb;
        logic [31:0] exp_aw, exp_ar;
        int exp_stall, n_stall, n_aw, n_w, n_b, n_ar, n_r, n_sel;
        int aw_c, w_c, b_c, ar_c, r_c;
        bit done;
        wb        = vv & vd;
        exp_aw    = ({14'd0, vtag} << 14) | (((addr >> 4) & 32'h3FF) << 4);
        exp_ar    = addr & 32'hFFFF_FFF0;
        exp_stall = 3 + ar_dly + r_dly + (wb ? (2 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly) : 0);
        {n_stall, n_aw, n_w, n_b, n_ar, n_r, n_sel} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        done = 1'b0;

        req_valid_i    = 1'b1;
        hit_i          = 1'b0;
        opcode_i       = ld ? 5'd11 : 5'd12;
        address_i      = addr;
        victim_valid_i = vv;
        victim_dirty_i = vd;
        victim_tag_i   = vtag;
        victim_data_i  = vdata;

        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            if (stall_o) n_stall++;
            if (n_sel > 0 && !stall_o) begin
                done = 1'b1;
            end else begin
                if (sel_o) begin
                    n_sel++;
                    tests_run++;
                    if ({array_we_o, load_miss_o, stall_o, axi_data_reg_o} !== {1'b1, ld, 1'b1, rdata}) begin
                        tests_failed++;
                        $display("FAIL %s upd: we/lm/stall/data=%b/%b/%b/%h required 1/%b/1/%h",
                                 name, array_we_o, load_miss_o, stall_o, axi_data_reg_o, ld, rdata);
                    end
                end else if (array_we_o) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL %s we_without_sel: array_we_o=1 required 0", name);
                end
                if (bus.m_awvalid) begin
                    tests_run++;
                    if (bus.m_awaddr !== exp_aw || !wb || n_aw != 0) begin
                        tests_failed++;
                        $display("FAIL %s aw: awaddr=%h beats=%0d wb=%b required awaddr=%h single beat only on dirty victim",
                                 name, bus.m_awaddr, n_aw, wb, exp_aw);
                    end
                    bus.m_awready = (aw_c == aw_dly);
                    aw_c++;
                    if (bus.m_awready) n_aw++;
                end else begin
                    bus.m_awready = 1'b0;
                end
                if (bus.m_wvalid) begin
                    tests_run++;
                    if (bus.m_wdata !== vdata || bus.m_wstrb !== 4'hF || !wb || n_w != 0) begin
                        tests_failed++;
                        $display("FAIL %s w: wdata=%h wstrb=%h beats=%0d required wdata=%h wstrb=f single beat",
                                 name, bus.m_wdata, bus.m_wstrb, n_w, vdata);
                    end
                    bus.m_wready = (w_c == w_dly);
                    w_c++;
                    if (bus.m_wready) n_w++;
                end else begin
                    bus.m_wready = 1'b0;
                end
                if (bus.m_bready) begin
                    tests_run++;
                    if (n_aw != 1 || n_w != 1) begin
                        tests_failed++;
                        $display("FAIL %s b_order: bready with aw=%0d w=%0d beats required 1/1", name, n_aw, n_w);
                    end
                    bus.m_bvalid = (b_c == b_dly);
                    bus.m_bresp  = bresp;
                    b_c++;
                    if (bus.m_bvalid) n_b++;
                end else begin
                    bus.m_bvalid = 1'b0;
                end
                if (bus.m_arvalid) begin
                    tests_run++;
                    if (bus.m_araddr !== exp_ar || n_ar != 0 || (wb && n_b != 1)) begin
                        tests_failed++;
                        $display("FAIL %s ar: araddr=%h ar_beats=%0d b_beats=%0d required araddr=%h after write-back",
                                 name, bus.m_araddr, n_ar, n_b, exp_ar);
                    end
                    bus.m_arready = (ar_c == ar_dly);
                    ar_c++;
                    if (bus.m_arready) n_ar++;
                end else begin
                    bus.m_arready = 1'b0;
                end
                if (bus.m_rready) begin
                    bus.m_rvalid = (r_c == r_dly);
                    bus.m_rdata  = rdata;
                    bus.m_rresp  = rresp;
                    r_c++;
                    if (bus.m_rvalid) n_r++;
                end else begin
                    bus.m_rvalid = 1'b0;
                end
            end
        end
        clear_slave();
        err_model = err_model | (wb && bresp != 2'b00) | (rresp != 2'b00);

        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s timeout: miss did not finish within 100 cycles", name);
        end
        tests_run++;
        if (n_stall != exp_stall) begin
            tests_failed++;
            $display("FAIL %s stall_cycles: got %0d required %0d", name, n_stall, exp_stall);
        end
        tests_run++;
        if ({n_sel, n_aw, n_w, n_b, n_ar, n_r} !== {32'd1, 32'(wb), 32'(wb), 32'(wb), 32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL %s beats: sel=%0d aw=%0d w=%0d b=%0d ar=%0d r=%0d required 1/%0d/%0d/%0d/1/1",
                     name, n_sel, n_aw, n_w, n_b, n_ar, n_r, wb, wb, wb);
        end
        tests_run++;
        if (err_o !== err_model || axi_data_reg_o !== rdata) begin
            tests_failed++;
            $display("FAIL %s after: err_o=%b data=%h required err_o=%b data=%h",
                     name, err_o, axi_data_reg_o, err_model, rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid_i = 1'b0; hit_i = 1'b0; opcode_i = '0; address_i = '0;
        victim_valid_i = 1'b0; victim_dirty_i = 1'b0; victim_tag_i = '0; victim_data_i = '0;
        clear_slave();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({stall_o, sel_o, load_miss_o, array_we_o, err_o} !== 5'b0 || axi_data_reg_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: stall/sel/lm/we/err=%b data=%h required 00000 data=0",
                     {stall_o, sel_o, load_miss_o, array_we_o, err_o}, axi_data_reg_o);
        end
        tests_run++;
        if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_axi: aw/w/b/ar/r=%b required 00000",
                     {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready});
        end
        reset = 1'b0;
        err_model = 1'b0;
    endtask

    task automatic test_clean_load();
        do_miss("clean_load", 32'h1234_5670, 1'b1, 1'b0, 1'b0, 18'h1, 32'h1111_1111,
                32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_dirty_store();
        do_miss("dirty_store", 32'h0001_5554, 1'b0, 1'b1, 1'b1, 18'h2AAAA, 32'hCAFE_F00D,
                32'h0BAD_CAFE, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_aw_w_skew();
        do_miss("aw_w_skew", 32'h8765_4320, 1'b1, 1'b1, 1'b1, 18'h3_0F0F, 32'h5A5A_A5A5,
                32'h1357_9BDF, 2'b00, 2'b00, 0, 3, 1, 2, 1);
    endtask

    task automatic test_rresp_err();
        do_miss("rresp_err", 32'h0000_ABC0, 1'b1, 1'b0, 1'b1, 18'h0, 32'h0,
                32'h7777_0000, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        do_miss("err_sticky", 32'h4444_0010, 1'b0, 1'b1, 1'b0, 18'h5, 32'h0,
                32'h2468_ACE0, 2'b00, 2'b00, 0, 0, 0, 1, 2);
    endtask

    task automatic test_no_miss();
        for (int i = 0; i < 12; i++) begin
            req_valid_i = 1'b1;
            address_i   = $urandom;
            if (i % 2 == 0) begin
                hit_i    = 1'b1;
                opcode_i = (i % 4 == 0) ? 5'd11 : 5'd12;
            end else begin
                hit_i    = 1'b0;
                opcode_i = 5'($urandom_range(0, 10));
            end
            victim_valid_i = 1'b1;
            victim_dirty_i = 1'b1;
            @(negedge clk);
            tests_run++;
            if ({stall_o, sel_o, array_we_o, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid} !== 6'b0) begin
                tests_failed++;
                $display("FAIL no_miss: stall/sel/we/awv/wv/arv=%b required 000000 (hit=%b op=%0d)",
                         {stall_o, sel_o, array_we_o, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid},
                         hit_i, opcode_i);
            end
        end
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bit reached = 1'b0;
        req_valid_i = 1'b1; hit_i = 1'b0; opcode_i = 5'd11; address_i = 32'h0F0F_0F00;
        victim_valid_i = 1'b0; victim_dirty_i = 1'b0;
        for (int cyc = 0; cyc < 10 && !reached; cyc++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            bus.m_arready = bus.m_arvalid;
            if (bus.m_rready) reached = 1'b1;
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL reset_mid_reach: rready never seen required within 10 cycles");
        end
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b1;
        bus.m_rdata   = 32'hFFFF_0000;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_slave();
        err_model = 1'b0;
        tests_run++;
        if ({stall_o, sel_o, load_miss_o, array_we_o, err_o, bus.m_rready, bus.m_arvalid} !== 7'b0 ||
            axi_data_reg_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: stall/sel/lm/we/err/rr/arv=%b data=%h required 0000000 data=0",
                     {stall_o, sel_o, load_miss_o, array_we_o, err_o, bus.m_rready, bus.m_arvalid},
                     axi_data_reg_o);
        end
        do_miss("after_reset", 32'h3333_3330, 1'b1, 1'b1, 1'b1, 18'h1_2345, 32'h9999_8888,
                32'h0000_4242, 2'b00, 2'b00, 1, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            do_miss("random", $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 18'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00,
                    ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_dirty_store();
        test_aw_w_skew();
        test_no_miss();
        test_rresp_err();
        test_reset_mid_read();
        test_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
